// File: rtl/alu32.sv
// alu32: registered 32-bit MIPS execute-stage ALU with zero/carry/overflow/invalid flags.
module alu32 #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] input_a,
    input  logic [WORD_SIZE-1:0] input_b,
    input  logic [3:0]           control,
    output logic [WORD_SIZE-1:0] result,
    output logic                 zero,
    output logic                 cout,
    output logic                 err_overflow,
    output logic                 err_invalid_control,
    output logic                 finished
);
    localparam logic [3:0] CONTROL_AND          = 4'h0;
    localparam logic [3:0] CONTROL_OR           = 4'h1;
    localparam logic [3:0] CONTROL_ADD          = 4'h2;
    localparam logic [3:0] CONTROL_ADD_UNSIGNED = 4'h3;
    localparam logic [3:0] CONTROL_SUB          = 4'h6;
    localparam logic [3:0] CONTROL_SLT          = 4'h7;
    localparam logic [3:0] CONTROL_NOR          = 4'hC;
    localparam int MSB = WORD_SIZE - 1;

    logic [WORD_SIZE:0]   sum, diff;
    logic [WORD_SIZE-1:0] r;
    logic                 c, o, inv;

    assign sum  = {1'b0, input_a} + {1'b0, input_b};
    // subtraction as a + ~b + 1 so the carry reads as "no borrow"
    assign diff = {1'b0, input_a} + {1'b0, ~input_b} + (WORD_SIZE+1)'(1);

    always_comb begin
        r   = '0;
        c   = 1'b0;
        o   = 1'b0;
        inv = 1'b0;
        case (control)
            CONTROL_AND: r = input_a & input_b;
            CONTROL_OR:  r = input_a | input_b;
            CONTROL_NOR: r = ~(input_a | input_b);
            CONTROL_ADD_UNSIGNED: begin
                {c, r} = sum;
                o = sum[WORD_SIZE];
            end
            CONTROL_ADD: begin
                {c, r} = sum;
                o = (input_a[MSB] == input_b[MSB]) && (sum[MSB] != input_a[MSB]);
            end
            CONTROL_SUB: begin
                {c, r} = diff;
                o = (input_a[MSB] != input_b[MSB]) && (diff[MSB] != input_a[MSB]);
            end
            CONTROL_SLT: r = {{(WORD_SIZE-1){1'b0}}, $signed(input_a) < $signed(input_b)};
            default:     inv = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            result              <= '0;
            zero                <= 1'b1;
            cout                <= 1'b0;
            err_overflow        <= 1'b0;
            err_invalid_control <= 1'b0;
            finished            <= 1'b0;
        end else if (start) begin
            result              <= r;
            zero                <= (r == '0);
            cout                <= c;
            err_overflow        <= o;
            err_invalid_control <= inv;
            finished            <= 1'b1;
        end else begin
            finished            <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu32.sv
// tb_alu32: scoreboard bench comparing alu32 against a wide-arithmetic reference model.
module tb_alu32;
    logic        clock, reset, start;
    logic [31:0] input_a, input_b, result;
    logic [3:0]  control;
    logic        zero, cout, err_overflow, err_invalid_control, finished;

    alu32 dut (
        .clock(clock), .reset(reset), .start(start),
        .input_a(input_a), .input_b(input_b), .control(control),
        .result(result), .zero(zero), .cout(cout),
        .err_overflow(err_overflow), .err_invalid_control(err_invalid_control),
        .finished(finished)
    );

    typedef struct {
        logic [31:0] a, b;
        logic [3:0]  op;
        logic [31:0] r;
        logic        z, c, o, inv;
    } exp_t;

    exp_t exp_q[$];
    exp_t last;
    int checks = 0;
    int errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic [3:0] op);
        exp_t e;
        longint sa, sb, ua, ub, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        e.a = a; e.b = b; e.op = op;
        e.r = '0; e.c = 1'b0; e.o = 1'b0; e.inv = 1'b0;
        if (op == dut.CONTROL_AND) e.r = a & b;
        else if (op == dut.CONTROL_OR) e.r = a | b;
        else if (op == dut.CONTROL_NOR) e.r = ~(a | b);
        else if (op == dut.CONTROL_ADD_UNSIGNED) begin
            e.r = 32'(ua + ub);
            e.c = (ua + ub) > 64'sd4294967295;
            e.o = e.c;
        end else if (op == dut.CONTROL_ADD) begin
            e.r = 32'(ua + ub);
            e.c = (ua + ub) > 64'sd4294967295;
            s = sa + sb;
            e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == dut.CONTROL_SUB) begin
            e.r = 32'(ua - ub);
            e.c = ua >= ub;
            s = sa - sb;
            e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == dut.CONTROL_SLT) e.r = (sa < sb) ? 32'd1 : 32'd0;
        else e.inv = 1'b1;
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    task automatic issue(logic [31:0] a, logic [31:0] b, logic [3:0] op);
        @(negedge clock);
        input_a = a; input_b = b; control = op; start = 1'b1;
        last = model(a, b, op);
        exp_q.push_back(last);
    endtask

    task automatic check_outputs(string name, exp_t e, logic fin);
        checks++;
        if (result !== e.r || zero !== e.z || cout !== e.c || err_overflow !== e.o ||
            err_invalid_control !== e.inv || finished !== fin) begin
            errors++;
            $display("FAIL %s a=%h b=%h op=%h got r=%h z=%b c=%b o=%b inv=%b fin=%b want r=%h z=%b c=%b o=%b inv=%b fin=%b",
                     name, e.a, e.b, e.op, result, zero, cout, err_overflow, err_invalid_control, finished,
                     e.r, e.z, e.c, e.o, e.inv, fin);
        end
    endtask

    always @(negedge clock) begin
        if (finished === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_finished got finished=1 want no pending op");
            end else check_outputs("scoreboard", exp_q.pop_front(), 1'b1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got still running want finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t rst_e;
        logic [3:0] ops [7];
        rst_e = '{a: 32'd0, b: 32'd0, op: 4'h0, r: 32'd0, z: 1'b1, c: 1'b0, o: 1'b0, inv: 1'b0};
        ops = '{dut.CONTROL_AND, dut.CONTROL_OR, dut.CONTROL_ADD, dut.CONTROL_ADD_UNSIGNED,
                dut.CONTROL_SUB, dut.CONTROL_SLT, dut.CONTROL_NOR};
        reset = 1'b1; start = 1'b0; input_a = '0; input_b = '0; control = '0;
        repeat (2) @(negedge clock);
        check_outputs("reset_state", rst_e, 1'b0);
        reset = 1'b0;

        issue(32'h0000FF00, 32'h000000FF, dut.CONTROL_AND);
        issue(32'hFFFFFFFF, 32'h0000000F, dut.CONTROL_OR);
        issue(32'h1, 32'h1, dut.CONTROL_NOR);
        issue(32'd1234, 32'd4321, dut.CONTROL_ADD_UNSIGNED);
        issue(32'hFFFFFFFF, 32'h1, dut.CONTROL_ADD_UNSIGNED);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, dut.CONTROL_ADD_UNSIGNED);
        issue(32'hFFFFFFFF, 32'h1, dut.CONTROL_ADD);
        issue(32'h7FFFFFFF, 32'h1, dut.CONTROL_ADD);
        issue(32'h80000000, 32'hFFFFFFFF, dut.CONTROL_ADD);
        issue(32'h80000000, 32'h80000000, dut.CONTROL_ADD);
        issue(32'd100, 32'd101, dut.CONTROL_SUB);
        issue(32'h0, 32'hFFFFFFFF, dut.CONTROL_SUB);
        issue(32'h80000000, 32'h1, dut.CONTROL_SUB);
        issue(32'h7FFFFFFF, 32'h80000000, dut.CONTROL_SUB);
        issue(32'd1, 32'd2, dut.CONTROL_SLT);
        issue(32'd1, 32'd1, dut.CONTROL_SLT);
        issue(32'hFFFFFFFE, 32'hFFFFFFFF, dut.CONTROL_SLT);
        issue(32'h0, 32'hFFFFFFFF, dut.CONTROL_SLT);
        issue(32'hFFFFFFFF, 32'h0, dut.CONTROL_SLT);
        issue(32'h80000000, 32'h7FFFFFFF, dut.CONTROL_SLT);
        issue(32'h12345678, 32'h9ABCDEF0, 4'hF);

        // start dropped with new operands present: outputs must hold
        @(negedge clock);
        start = 1'b0; input_a = 32'hDEADBEEF; input_b = 32'h1; control = dut.CONTROL_ADD;
        @(negedge clock);
        check_outputs("hold", last, 1'b0);
        @(negedge clock);
        check_outputs("hold2", last, 1'b0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
            logic [3:0] op;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 3) == 0) a[31:30] = 2'($urandom_range(0, 3));
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clock);
                start = 1'b0;
            end
            issue(a, b, op);
        end

        // reset wins over start
        @(negedge clock);
        reset = 1'b1; start = 1'b1; input_a = 32'h1; input_b = 32'h2; control = dut.CONTROL_ADD;
        @(negedge clock);
        check_outputs("reset_with_start", rst_e, 1'b0);
        reset = 1'b0; start = 1'b0;
        repeat (2) @(negedge clock);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
